mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Serves the instruction cache and the load/store buffer (LSB) from the single byte-wide RAM/IO port.
//  Responds to icache word fetches (req/addr in, rdy pulse + word out) and LSB loads/stores of 1/2/4 bytes.
//  Serialises each access into byte cycles with a 1-cycle RAM read latency; handles IO back-pressure and rollback.
// PARAMETERS
//  IO_BASE   32'h30000  first IO address; data_addr >= IO_BASE is an IO access (store stalls on io_buffer_full)
// PORTS
//  clk            in   1   clock, all state updates on rising edge
//  rst            in   1   synchronous active-high reset
//  rdy            in   1   global enable; when 0 all state and outputs hold
//  clear          in   1   rollback: abort in-flight fetch/load
//  mem_din        in   8   RAM read byte (data for the previous cycle's mem_a)
//  mem_dout       out  8   RAM write byte
//  mem_a          out  32  RAM byte address
//  mem_wr         out  1   1 = write mem_dout to mem_a this cycle
//  io_buffer_full in   1   IO write buffer full
//  inst_req       in   1   icache fetch request, held until inst_rdy seen
//  inst_addr      in   32  fetch address (word aligned)
//  inst_rdy       out  1   one-cycle pulse: inst_out valid
//  inst_out       out  32  fetched word, little-endian
//  data_req       in   1   LSB request, held until data_rdy seen
//  data_wr        in   1   1 = store, 0 = load
//  data_len       in   2   0 = byte, 1 = half, 2 = word (3 illegal, treated as word)
//  data_addr      in   32  access address
//  data_in        in   32  store data, low N bytes used
//  data_rdy       out  1   one-cycle pulse: load data valid / store complete
//  data_out       out  32  load result, zero-extended
// BEHAVIOUR
//  Reset: state IDLE; mem_a=0, mem_dout=0, mem_wr=0, inst_rdy=0, inst_out=0, data_rdy=0, data_out=0, counters 0.
//  States: IDLE, IFETCH, LOAD, STORE. rdy=0 freezes everything (no capture, no issue, pulses held).
//  IDLE: rdy pulse from previous access is dropped this cycle; no request accepted while inst_rdy|data_rdy=1.
//   Else data_req wins over inst_req (both high -> LOAD/STORE). Request registered at acceptance edge (E0).
//  Read (IFETCH N=4, LOAD N=len bytes): cycle k+1 (k=0..N-1): mem_a=addr+k, mem_wr=0.
//   Byte k taken from mem_din at end of cycle k+2 into bits [8k+7:8k]; mem_a=0 after last issue.
//   Cycle N+2: rdy pulse high with data; state IDLE. Word fetch: inst_rdy in cycle 6 after E0.
//  STORE: cycle k+1: mem_wr=1, mem_a=addr+k, mem_dout=data_in[8k+7:8k]; cycle N+1: mem_wr=0, data_rdy=1, IDLE.
//   IO store (addr>=IO_BASE): byte issued only when io_buffer_full=0 at issue edge; else idle cycle
//   (mem_wr=0), k not advanced. IO loads not gated.
//  clear=1: IFETCH/LOAD -> IDLE next edge, mem_wr=0, mem_a=0, no rdy pulse, partial data discarded.
//   STORE ignores clear (already committed) and completes normally. clear in IDLE: no accept that edge.
//  Address arithmetic modulo 2^32 (addr+k wraps). mem_wr never high outside STORE.
//  Reset mid-access: abort immediately, no rdy pulse, outputs to reset values.
// TESTING
//  RAM model 1-cycle latency; bytes 0x100..0x103 = 13,05,00,00 -> inst_req addr 0x100: inst_rdy 1 cycle, inst_out=0x00000513, cycle 6.
//  data_req+inst_req same edge, load word 0x200 (=0xDEADBEEF) -> data_rdy first with 0xDEADBEEF, then fetch served.
//  Store half 0x1234ABCD to 0x301 -> mem_wr cycles: (0x301,CD),(0x302,AB); data_rdy next cycle; RAM updated.
//  Store byte 0x41 to 0x30000, io_buffer_full=1 for 3 cycles -> mem_wr stays 0 3 cycles, then single write.
//  Fetch in flight, clear at cycle 3 -> IDLE, no inst_rdy; re-request returns correct word.
//  rdy=0 for 2 cycles mid load byte at 0x7 -> same result, latency +2; rst mid-store -> all outputs 0.

Source files
------------

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating icache fetches and LSB loads/stores onto a single
// RAM/IO port with 1-cycle read latency, IO write back-pressure and rollback.
module mem_ctrl #(
    parameter logic [31:0] IO_BASE = 32'h30000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_rdy,
    output logic [31:0] inst_out,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_len,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_in,
    output logic        data_rdy,
    output logic [31:0] data_out
);

    typedef enum logic [1:0] {StIdle, StIfetch, StLoad, StStore} state_e;

    state_e      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rbuf_q;
    logic [2:0]  nbytes_q;
    logic [2:0]  cnt_q;
    logic        frz_q;
    logic [7:0]  din_sv_q;

    logic [7:0]  din;
    logic [1:0]  byte_idx;
    logic [31:0] rd_word;
    logic        store_gated;

    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // mem_din only carries the byte for the last active cycle's address on the first frozen
    // cycle, so it is saved there and replayed on the resume edge.
    assign din         = frz_q ? din_sv_q : mem_din;
    assign byte_idx    = 2'(cnt_q - 3'd2);
    assign store_gated = (addr_q >= IO_BASE) && io_buffer_full;

    always_comb begin
        rd_word = rbuf_q;
        rd_word[8*byte_idx +: 8] = din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            addr_q   <= '0;
            wdata_q  <= '0;
            rbuf_q   <= '0;
            nbytes_q <= '0;
            cnt_q    <= '0;
            frz_q    <= 1'b0;
            din_sv_q <= '0;
            mem_a    <= '0;
            mem_dout <= '0;
            mem_wr   <= 1'b0;
            inst_rdy <= 1'b0;
            inst_out <= '0;
            data_rdy <= 1'b0;
            data_out <= '0;
        end else if (!rdy) begin
            if (!frz_q) din_sv_q <= mem_din;
            frz_q <= 1'b1;
        end else begin
            frz_q <= 1'b0;
            unique case (state)
                StIdle: begin
                    inst_rdy <= 1'b0;
                    data_rdy <= 1'b0;
                    mem_wr   <= 1'b0;
                    if (!clear && !inst_rdy && !data_rdy) begin
                        if (data_req) begin
                            addr_q   <= data_addr;
                            wdata_q  <= data_in;
                            nbytes_q <= len_bytes(data_len);
                            rbuf_q   <= '0;
                            if (data_wr) begin
                                state <= StStore;
                                if (data_addr >= IO_BASE && io_buffer_full) begin
                                    cnt_q <= 3'd0;
                                end else begin
                                    mem_wr   <= 1'b1;
                                    mem_a    <= data_addr;
                                    mem_dout <= data_in[7:0];
                                    cnt_q    <= 3'd1;
                                end
                            end else begin
                                state <= StLoad;
                                mem_a <= data_addr;
                                cnt_q <= 3'd1;
                            end
                        end else if (inst_req) begin
                            state    <= StIfetch;
                            addr_q   <= inst_addr;
                            nbytes_q <= 3'd4;
                            rbuf_q   <= '0;
                            mem_a    <= inst_addr;
                            cnt_q    <= 3'd1;
                        end
                    end
                end
                StIfetch, StLoad: begin
                    if (clear) begin
                        state  <= StIdle;
                        mem_a  <= '0;
                        mem_wr <= 1'b0;
                    end else begin
                        mem_a <= (cnt_q < nbytes_q) ? addr_q + 32'(cnt_q) : '0;
                        // cnt_q counts cycles since acceptance; the byte issued in cycle k+1
                        // arrives in cycle k+2.
                        if (cnt_q >= 3'd2) rbuf_q <= rd_word;
                        if (cnt_q == nbytes_q + 3'd1) begin
                            state <= StIdle;
                            if (state == StIfetch) begin
                                inst_out <= rd_word;
                                inst_rdy <= 1'b1;
                            end else begin
                                data_out <= rd_word;
                                data_rdy <= 1'b1;
                            end
                        end
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                StStore: begin
                    if (cnt_q == nbytes_q) begin
                        mem_wr   <= 1'b0;
                        mem_a    <= '0;
                        data_rdy <= 1'b1;
                        state    <= StIdle;
                    end else if (store_gated) begin
                        mem_wr <= 1'b0;
                    end else begin
                        mem_wr   <= 1'b1;
                        mem_a    <= addr_q + 32'(cnt_q);
                        mem_dout <= wdata_q[8*cnt_q[1:0] +: 8];
                        cnt_q    <= cnt_q + 3'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized load/store/fetch traffic
// checked against a transaction-level byte-array reference model.
module tb_mem_ctrl;

    localparam logic [31:0] IO_BASE = 32'h30000;
    localparam int unsigned RAM_SZ  = 262144;

    logic        clk = 1'b0;
    logic        rst, rdy, clear, io_buffer_full;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        inst_req, inst_rdy;
    logic [31:0] inst_addr, inst_out;
    logic        data_req, data_wr, data_rdy;
    logic [1:0]  data_len;
    logic [31:0] data_addr, data_in, data_out;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [7:0]  ram     [RAM_SZ];
    logic [7:0]  ref_mem [RAM_SZ];
    logic [39:0] wr_q[$];
    logic [39:0] io_q[$];

    mem_ctrl #(.IO_BASE(IO_BASE)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdy(inst_rdy), .inst_out(inst_out),
        .data_req(data_req), .data_wr(data_wr), .data_len(data_len), .data_addr(data_addr),
        .data_in(data_in), .data_rdy(data_rdy), .data_out(data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(int unsigned i);
        case (i)
            32'h100: return 8'h13;
            32'h101: return 8'h05;
            32'h102, 32'h103: return 8'h00;
            32'h200: return 8'hEF;
            32'h201: return 8'hBE;
            32'h202: return 8'hAD;
            32'h203: return 8'hDE;
            32'h7:   return 8'h5A;
            32'h0:   return 8'h11;
            default: return 8'(i * 13 + (i >> 7) + 3);
        endcase
    endfunction

    // RAM/IO port model: 1-cycle read latency, writes land in RAM or the IO log.
    initial begin
        for (int i = 0; i < RAM_SZ; i++) ram[i] = init_byte(i);
        mem_din = 8'h00;
        forever begin
            @(posedge clk);
            mem_din <= ram[mem_a[17:0]];
            if (mem_wr && rdy) begin
                wr_q.push_back({mem_a, mem_dout});
                if (mem_a >= IO_BASE) io_q.push_back({mem_a, mem_dout});
                else ram[mem_a[17:0]] = mem_dout;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] len);
        return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] len);
        logic [31:0] v = '0;
        for (int k = 0; k < nbytes(len); k++) v[8*k +: 8] = ref_mem[(addr + 32'(k)) & 32'h3FFFF];
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [1:0] len, input logic [31:0] d);
        for (int k = 0; k < nbytes(len); k++) begin
            logic [31:0] a = addr + 32'(k);
            if (addr < IO_BASE) ref_mem[a & 32'h3FFFF] = d[8*k +: 8];
        end
    endtask

    // frz_at != 0 drops rdy at that cycle for two cycles.
    task automatic data_xfer(input bit wr, input logic [1:0] len, input logic [31:0] addr,
                             input logic [31:0] din, input int frz_at,
                             output logic [31:0] dout, output int lat);
        @(negedge clk);
        data_req = 1'b1; data_wr = wr; data_len = len; data_addr = addr; data_in = din;
        lat = 0;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (frz_at != 0 && lat == frz_at) rdy = 1'b0;
            if (frz_at != 0 && lat == frz_at + 2) rdy = 1'b1;
            if (data_rdy) break;
        end
        if (lat >= 60) check("data_timeout", {31'd0, data_rdy}, 32'd1);
        dout = data_out;
        data_req = 1'b0;
    endtask

    task automatic inst_xfer(input logic [31:0] addr, input int frz_at,
                             output logic [31:0] w, output int lat);
        @(negedge clk);
        inst_req = 1'b1; inst_addr = addr;
        lat = 0;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (frz_at != 0 && lat == frz_at) rdy = 1'b0;
            if (frz_at != 0 && lat == frz_at + 2) rdy = 1'b1;
            if (inst_rdy) break;
        end
        if (lat >= 60) check("inst_timeout", {31'd0, inst_rdy}, 32'd1);
        w = inst_out;
        inst_req = 1'b0;
    endtask

    initial begin
        logic [31:0] d, a;
        logic [1:0]  len;
        int          lat, cnt, frz;

        for (int i = 0; i < RAM_SZ; i++) ref_mem[i] = init_byte(i);
        rst = 1'b1; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_len = '0; data_addr = '0; data_in = '0;
        repeat (3) @(negedge clk);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'h0);
        check("rst_mem_dout", {24'd0, mem_dout}, 32'h0);
        check("rst_inst_rdy", {31'd0, inst_rdy}, 32'h0);
        check("rst_inst_out", inst_out, 32'h0);
        check("rst_data_rdy", {31'd0, data_rdy}, 32'h0);
        check("rst_data_out", data_out, 32'h0);
        rst = 1'b0;

        // Word fetch
        inst_xfer(32'h100, 0, d, lat);
        check("fetch_word", d, 32'h0000_0513);
        check("fetch_lat", 32'(lat), 32'd6);
        @(negedge clk);
        check("fetch_pulse", {31'd0, inst_rdy}, 32'h0);

        // Simultaneous requests: load wins
        @(negedge clk);
        data_req = 1'b1; data_wr = 1'b0; data_len = 2'd2; data_addr = 32'h200;
        inst_req = 1'b1; inst_addr = 32'h100;
        lat = 0;
        while (lat < 60 && !data_rdy && !inst_rdy) begin @(negedge clk); lat++; end
        check("arb_data_first", {31'd0, data_rdy}, 32'h1);
        check("arb_inst_not_yet", {31'd0, inst_rdy}, 32'h0);
        check("arb_load_word", data_out, 32'hDEAD_BEEF);
        check("arb_load_lat", 32'(lat), 32'd6);
        data_req = 1'b0;
        lat = 0;
        while (lat < 60 && !inst_rdy) begin @(negedge clk); lat++; end
        check("arb_fetch_word", inst_out, 32'h0000_0513);
        inst_req = 1'b0;

        // Store half
        wr_q.delete();
        data_xfer(1'b1, 2'd1, 32'h301, 32'h1234_ABCD, 0, d, lat);
        ref_store(32'h301, 2'd1, 32'h1234_ABCD);
        check("sth_lat", 32'(lat), 32'd3);
        check("sth_nwr", 32'(wr_q.size()), 32'd2);
        if (wr_q.size() == 2) begin
            check("sth_wr0", wr_q[0][31:0], {24'h000301, 8'hCD});
            check("sth_wr1", wr_q[1][31:0], {24'h000302, 8'hAB});
        end
        check("sth_ram", {16'd0, ram[32'h302], ram[32'h301]}, 32'h0000_ABCD);

        // IO store with back-pressure
        io_q.delete();
        @(negedge clk);
        io_buffer_full = 1'b1;
        data_req = 1'b1; data_wr = 1'b1; data_len = 2'd0; data_addr = IO_BASE; data_in = 32'h41;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("io_stall", {31'd0, mem_wr}, 32'h0);
        end
        io_buffer_full = 1'b0;
        @(negedge clk);
        check("io_wr", {31'd0, mem_wr}, 32'h1);
        check("io_addr_data", {mem_a[23:0], mem_dout}, {IO_BASE[23:0], 8'h41});
        @(negedge clk);
        check("io_done", {31'd0, data_rdy}, 32'h1);
        check("io_done_wr", {31'd0, mem_wr}, 32'h0);
        data_req = 1'b0;
        check("io_count", 32'(io_q.size()), 32'd1);

        // Rollback during fetch
        @(negedge clk);
        inst_req = 1'b1; inst_addr = 32'h100;
        repeat (3) @(negedge clk);
        clear = 1'b1; inst_req = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        check("clr_mem_a", mem_a, 32'h0);
        cnt = 0;
        repeat (8) begin @(negedge clk); if (inst_rdy) cnt++; end
        check("clr_no_rdy", 32'(cnt), 32'd0);
        inst_xfer(32'h100, 0, d, lat);
        check("clr_refetch", d, 32'h0000_0513);

        // Freeze mid load
        data_xfer(1'b0, 2'd0, 32'h7, 32'h0, 2, d, lat);
        check("frz_load", d, 32'h0000_005A);
        check("frz_lat", 32'(lat), 32'd5);

        // Address wrap
        data_xfer(1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0, 0, d, lat);
        check("wrap_load", d, ref_load(32'hFFFF_FFFF, 2'd1));

        // Random traffic
        for (int t = 0; t < 60; t++) begin
            frz = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            a   = 32'h1000 + $urandom_range(0, 32'hFF0);
            len = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0: begin
                    a = {a[31:2], 2'b00};
                    inst_xfer(a, frz, d, lat);
                    check("rnd_fetch", d, ref_load(a, 2'd2));
                    check("rnd_fetch_lat", 32'(lat), 32'(6 + (frz != 0 ? 2 : 0)));
                end
                1: begin
                    data_xfer(1'b0, len, a, 32'h0, frz, d, lat);
                    check("rnd_load", d, ref_load(a, len));
                    check("rnd_load_lat", 32'(lat), 32'(nbytes(len) + 2 + (frz != 0 ? 2 : 0)));
                end
                default: begin
                    d = $urandom;
                    data_xfer(1'b1, len, a, d, 0, d, lat);
                    ref_store(a, len, data_in);
                    check("rnd_store_lat", 32'(lat), 32'(nbytes(len) + 1));
                end
            endcase
        end

        // Reset mid-store
        @(negedge clk);
        data_req = 1'b1; data_wr = 1'b1; data_len = 2'd2; data_addr = IO_BASE + 32'h10;
        data_in = 32'hA5A5_5A5A;
        repeat (2) @(negedge clk);
        rst = 1'b1; data_req = 1'b0;
        @(negedge clk);
        check("rstmid_wr", {31'd0, mem_wr}, 32'h0);
        check("rstmid_a", mem_a, 32'h0);
        check("rstmid_dout", {24'd0, mem_dout}, 32'h0);
        check("rstmid_rdy", {30'd0, data_rdy, inst_rdy}, 32'h0);
        check("rstmid_outs", data_out | inst_out, 32'h0);
        rst = 1'b0;
        inst_xfer(32'h200, 0, d, lat);
        check("post_rst_fetch", d, 32'hDEAD_BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
